// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for a 5-stage pipeline; holds one pending redirect across a busy fetch.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int PC_W   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_redirect_i,
  input  logic [PC_W-1:0]   ex_target_i,
  input  logic              imem_busy_i,
  input  logic              dmem_busy_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              flush_wb_o,
  output logic              redirect_valid_o,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [63:0]       perf_stall_cycles_o,
  output logic [63:0]       perf_loaduse_o,
  output logic [63:0]       perf_redirects_o,
`endif
  output logic [PC_W-1:0]   redirect_pc_o
);

  typedef enum logic [0:0] {RUN = 1'b0, REDIR_PEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              luh_s, loaduse_win_s;
  logic              stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
  logic              flush_id_s, flush_ex_s, flush_wb_s, redirect_valid_s;
  logic [PC_W-1:0]   redirect_pc_s;

  assign luh_s = ex_valid_i && ex_is_load_i && id_valid_i && (ex_rd_i != {REG_AW{1'b0}}) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) || (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  // Next-state and per-stage control decode
  always_comb begin
    state_d          = state_q;
    pend_pc_d        = pend_pc_q;
    loaduse_win_s    = 1'b0;
    stall_if_s       = 1'b0;
    stall_id_s       = 1'b0;
    stall_ex_s       = 1'b0;
    stall_mem_s      = 1'b0;
    flush_id_s       = 1'b0;
    flush_ex_s       = 1'b0;
    flush_wb_s       = 1'b0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = {PC_W{1'b0}};
    case (state_q)
      RUN: begin
        if (dmem_busy_i) begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          stall_ex_s  = 1'b1;
          stall_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
        end else if (ex_redirect_i && !imem_busy_i) begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = ex_target_i;
          flush_id_s       = 1'b1;
          flush_ex_s       = 1'b1;
        end else if (ex_redirect_i) begin
          flush_id_s = 1'b1;
          flush_ex_s = 1'b1;
          stall_if_s = 1'b1;
          pend_pc_d  = ex_target_i;
          state_d    = REDIR_PEND;
        end else if (luh_s) begin
          stall_if_s    = 1'b1;
          stall_id_s    = 1'b1;
          flush_ex_s    = 1'b1;
          loaduse_win_s = 1'b1;
        end else if (imem_busy_i) begin
          stall_if_s = 1'b1;
          flush_id_s = 1'b1;
        end else begin
          stall_if_s = 1'b0;
        end
      end
      REDIR_PEND: begin
        // The wrong-path fetch is still in flight: discard whatever it returns.
        flush_id_s = 1'b1;
        if (imem_busy_i) begin
          stall_if_s = 1'b1;
        end else begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = pend_pc_q;
          state_d          = RUN;
        end
        if (dmem_busy_i) begin
          stall_ex_s  = 1'b1;
          stall_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
        end else begin
          stall_mem_s = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and pending-target registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      pend_pc_q <= {PC_W{1'b0}};
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign stall_if_o       = rst_ni & stall_if_s;
  assign stall_id_o       = rst_ni & stall_id_s;
  assign stall_ex_o       = rst_ni & stall_ex_s;
  assign stall_mem_o      = rst_ni & stall_mem_s;
  assign flush_id_o       = rst_ni & flush_id_s;
  assign flush_ex_o       = rst_ni & flush_ex_s;
  assign flush_wb_o       = rst_ni & flush_wb_s;
  assign redirect_valid_o = rst_ni & redirect_valid_s;
  assign redirect_pc_o    = rst_ni ? redirect_pc_s : {PC_W{1'b0}};

`ifdef PIPE_HAZARD_PERF_EN
  logic [63:0] perf_stall_q, perf_loaduse_q, perf_redir_q;

  // Saturating event counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q   <= 64'd0;
      perf_loaduse_q <= 64'd0;
      perf_redir_q   <= 64'd0;
    end else begin
      if (stall_if_s && (perf_stall_q != {64{1'b1}}))
        perf_stall_q <= perf_stall_q + 64'd1;
      if (loaduse_win_s && (perf_loaduse_q != {64{1'b1}}))
        perf_loaduse_q <= perf_loaduse_q + 64'd1;
      if (redirect_valid_s && (perf_redir_q != {64{1'b1}}))
        perf_redir_q <= perf_redir_q + 64'd1;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_loaduse_o      = perf_loaduse_q;
  assign perf_redirects_o    = perf_redir_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized check of pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_redirect, imem_busy, dmem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [63:0] ex_target;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, redirect_valid;
  logic [63:0] redirect_pc;
`ifdef PIPE_HAZARD_PERF_EN
  logic [63:0] perf_stall_cycles, perf_loaduse, perf_redirects;
  logic [63:0] m_stall = 64'd0, m_lu = 64'd0, m_rd = 64'd0;
`endif

  int total = 0;
  int bad = 0;

  // model state: whether a redirect is owed to fetch, and its target
  logic        pend_m = 1'b0;
  logic [63:0] pend_pc_m = 64'd0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.PC_W(64), .REG_AW(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
    .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
    .imem_busy_i(imem_busy), .dmem_busy_i(dmem_busy),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex), .stall_mem_o(stall_mem),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex), .flush_wb_o(flush_wb),
    .redirect_valid_o(redirect_valid),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cycles_o(perf_stall_cycles), .perf_loaduse_o(perf_loaduse),
    .perf_redirects_o(perf_redirects),
`endif
    .redirect_pc_o(redirect_pc)
  );

  // bit order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_wb redirect_valid
  wire [7:0] obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, redirect_valid};
  localparam logic [7:0] SIF = 8'h80, SID = 8'h40, SEX = 8'h20, SMEM = 8'h10;
  localparam logic [7:0] FID = 8'h08, FEX = 8'h04, FWB = 8'h02, RV = 8'h01;

  function automatic void model(output logic [7:0] e, output logic [63:0] epc,
                                output logic np, output logic [63:0] npc, output logic lw);
    logic luh;
    luh = ex_valid && ex_is_load && id_valid && ex_rd != 5'd0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e = 8'h00; epc = 64'd0; np = pend_m; npc = pend_pc_m; lw = 1'b0;
    if (!rst_n) begin
      np = 1'b0;
    end else if (pend_m) begin
      e = FID | (imem_busy ? SIF : RV) | (dmem_busy ? (SEX | SMEM | FWB) : 8'h00);
      if (!imem_busy) begin epc = pend_pc_m; np = 1'b0; end
    end else if (dmem_busy) e = SIF | SID | SEX | SMEM | FWB;
    else if (ex_redirect && !imem_busy) begin e = RV | FID | FEX; epc = ex_target; end
    else if (ex_redirect) begin e = FID | FEX | SIF; np = 1'b1; npc = ex_target; end
    else if (luh) begin e = SIF | SID | FEX; lw = 1'b1; end
    else if (imem_busy) e = SIF | FID;
  endfunction

  task automatic check8(input string tag, input logic [7:0] o, input logic [7:0] x);
    total++;
    assert (o === x) else begin bad++; $error("FAIL %s ctl observed=%b expected=%b", tag, o, x); end
  endtask

  task automatic check64(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin bad++; $error("FAIL %s value observed=%h expected=%h", tag, o, x); end
  endtask

  task automatic step(input string tag);
    logic [7:0] e; logic [63:0] epc; logic np; logic [63:0] npc; logic lw;
    @(negedge clk);
    model(e, epc, np, npc, lw);
    check8(tag, obs, e);
    check64(tag, redirect_pc, epc);
    @(posedge clk);
    if (rst_n) begin
`ifdef PIPE_HAZARD_PERF_EN
      if ((e & SIF) != 8'h00) m_stall++;
      if (lw) m_lu++;
      if ((e & RV) != 8'h00) m_rd++;
`endif
      pend_m = np; pend_pc_m = npc;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; ex_target = 64'd0;
    imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_luh(input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    ex_redirect = 1'b1; imem_busy = 1'b1; dmem_busy = 1'b1;
    #3;
    check8("reset_ctl", obs, 8'h00);
    check64("reset_pc", redirect_pc, 64'd0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    step("idle");

    set_luh(5'd5);           step("loaduse");
    idle();                  step("loaduse_clear");
    set_luh(5'd0);           step("loaduse_rd0");

    idle(); ex_redirect = 1'b1; ex_target = 64'h8000_0040; step("redir_now");
    idle();                  step("redir_now_run");

    ex_redirect = 1'b1; ex_target = 64'h1000; imem_busy = 1'b1; step("pend_c0");
    ex_redirect = 1'b0;      step("pend_c1");
    step("pend_c2");
    imem_busy = 1'b0;        step("pend_c3");
    step("pend_run");

    idle(); set_luh(5'd5); ex_redirect = 1'b1; ex_target = 64'h2468; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("dmem_hold");
    dmem_busy = 1'b0;        step("dmem_release");
    idle(); set_luh(5'd5); ex_redirect = 1'b1; ex_target = 64'h55; step("luh_vs_redir");

    idle(); ex_redirect = 1'b1; ex_target = 64'h3000; imem_busy = 1'b1; dmem_busy = 1'b1;
    step("dmem_first");
    dmem_busy = 1'b0;        step("enter_pend");
    ex_redirect = 1'b0; dmem_busy = 1'b1; step("pend_dmem_busy");
    imem_busy = 1'b0;        step("pend_dmem_redir");

    idle(); ex_redirect = 1'b1; ex_target = 64'h4000; imem_busy = 1'b1; step("pend_before_rst");
    rst_n = 1'b0; ex_redirect = 1'b1; imem_busy = 1'b0;
    #1;
    check8("rst_mid_pend", obs, 8'h00);
    check64("rst_mid_pend_pc", redirect_pc, 64'd0);
    @(posedge clk); #1;
    pend_m = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
    m_stall = 64'd0; m_lu = 64'd0; m_rd = 64'd0;
`endif
    idle(); rst_n = 1'b1;    step("after_rst_no_redir");

`ifdef PIPE_HAZARD_PERF_EN
    set_luh(5'd5); step("perf_lu1"); idle(); step("perf_gap");
    set_luh(5'd5); step("perf_lu2"); idle();
    ex_redirect = 1'b1; ex_target = 64'h10; step("perf_redir"); idle();
    @(negedge clk);
    check64("perf_loaduse", perf_loaduse, 64'd2);
    check64("perf_redirects", perf_redirects, 64'd1);
    check64("perf_stall", perf_stall_cycles, 64'd2);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_valid = 1'($urandom_range(0, 3) != 0); ex_is_load = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3));
      ex_redirect = 1'($urandom_range(0, 4) == 0);
      ex_target = {$urandom, $urandom};
      imem_busy = 1'($urandom_range(0, 2) == 0);
      dmem_busy = 1'($urandom_range(0, 4) == 0);
      step("random");
    end

`ifdef PIPE_HAZARD_PERF_EN
    @(negedge clk);
    check64("perf_stall_rand", perf_stall_cycles, m_stall);
    check64("perf_lu_rand", perf_loaduse, m_lu);
    check64("perf_rd_rand", perf_redirects, m_rd);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Combines four event sources into per-stage hold/bubble controls and one fetch redirect:
  - load-use hazards between ID and EX;
  - EX-stage control transfers (branch taken, JAL, JALR);
  - instruction-memory busy;
  - data-memory busy.
- Holds one pending redirect across a multi-cycle fetch, so the wrong-path instruction in flight is discarded.

Parameters:
PC_W, 64, width of program counter / redirect target
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  REG_AW  ID source register 1
id_rs2  in  REG_AW  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage holds a valid instruction
ex_rd  in  REG_AW  EX destination register
ex_is_load  in  1  EX instruction is a load (memRw = read)
ex_redirect  in  1  EX resolved a taken branch or jump
ex_target  in  PC_W  target of that redirect
imem_busy  in  1  fetch request outstanding, instruction not yet returned
dmem_busy  in  1  MEM-stage access outstanding
stall_if  out  1  hold PC / IF register
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
stall_mem  out  1  hold EX/MEM register
flush_id  out  1  insert bubble (valid=0) into IF/ID
flush_ex  out  1  insert bubble into ID/EX
flush_wb  out  1  insert bubble into MEM/WB
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  PC_W  redirect target

Behaviour:
- FSM states: RUN, REDIR_PEND. State and pend_pc register (PC_W) are reset asynchronously to RUN and 0.
- While reset is low, all outputs are forced to 0. All outputs are combinational from state, pend_pc and inputs; zero added latency.
- Load-use hazard term (luh) is asserted when all of the following hold:
  - ex_valid & ex_is_load & id_valid & ex_rd != 0;
  - (id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd).
- Priority per cycle in RUN, highest first:
  1. dmem_busy:
     - stall_if, stall_id, stall_ex and stall_mem = 1; flush_wb = 1.
     - ex_redirect and luh are ignored; EX is frozen and re-presents them.
     - No state change.
  2. ex_redirect with imem_busy = 0:
     - redirect_valid = 1, redirect_pc = ex_target.
     - flush_id = 1, flush_ex = 1. Stay in RUN.
  3. ex_redirect with imem_busy = 1:
     - flush_id = 1, flush_ex = 1, stall_if = 1, redirect_valid = 0.
     - pend_pc <= ex_target; next state REDIR_PEND.
  4. luh:
     - stall_if = 1, stall_id = 1, flush_ex = 1 (exactly one bubble).
     - Next cycle the load has left EX, so luh clears.
  5. imem_busy: stall_if = 1, flush_id = 1.
  6. Otherwise all outputs 0.
- In REDIR_PEND:
  - flush_id = 1 every cycle; the wrong-path fetch result is discarded.
  - stall_if = 1 while imem_busy.
  - When imem_busy = 0: redirect_valid = 1, redirect_pc = pend_pc; next state RUN.
  - dmem_busy in this state additionally asserts stall_mem, stall_ex and flush_wb, but does not block the redirect. EX holds a bubble, since flush_ex was asserted on entry.
  - A new ex_redirect is impossible in REDIR_PEND because EX is a bubble; it is ignored.
- Simultaneous luh and ex_redirect: the redirect wins; the ID instruction is flushed, so no interlock is needed.
- ex_rd = 0 never creates a load-use hazard.
- An asynchronous reset mid-pending drops the pending redirect; state returns to RUN.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, three additional outputs, each 64-bit, reset to 0 and saturating at all-ones:
  - perf_stall_cycles counts cycles with stall_if = 1;
  - perf_loaduse counts cycles where luh wins priority;
  - perf_redirects counts redirect_valid pulses.
- When not defined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, id_valid=1, id_use_rs2=1, id_rs2=5 -> one cycle with stall_if=stall_id=flush_ex=1; with ex_rd=0 -> all 0.
- Redirect, no fetch wait: ex_redirect=1, ex_target=0x80000040, imem_busy=0 -> same cycle redirect_valid=1, redirect_pc=0x80000040, flush_id=flush_ex=1, state stays RUN.
- Pending redirect:
  - Stimulus: ex_redirect=1, ex_target=0x1000 with imem_busy=1 for 3 cycles.
  - Cycles 0-2: stall_if=1, flush_id=1, redirect_valid=0.
  - Cycle 3 (imem_busy=0): redirect_valid=1, redirect_pc=0x1000; then RUN.
- dmem_busy=1 for 4 cycles with ex_redirect=1 and luh true -> stall_if/id/ex/mem=1 and flush_wb=1 each cycle, redirect_valid=0. Cycle after release: redirect taken.
- Reset low asserted during REDIR_PEND -> outputs 0 immediately; after release with imem_busy=0, no redirect_valid pulse.
- PIPE_HAZARD_PERF_EN: run load-use scenario twice plus one redirect -> perf_loaduse=2, perf_redirects=1, perf_stall_cycles=2.
